// File: rtl/summation_feeder_if.sv
// Bus bundle between the summation feeder and its neighbours: request
// channel, summation-stage drive/sense, and result channel.
// "slave" is the feeder's view; "master" is the environment's view.
interface summation_feeder_if #(
  parameter int N_W   = 4,
  parameter int SUM_W = 7
);
  logic             req_valid;
  logic             req_ready;
  logic [N_W-1:0]   req_n;
  logic [N_W-1:0]   sum_n;
  logic             sum_rst;
  logic [SUM_W-1:0] sum_in;
  logic             res_valid;
  logic             res_ready;
  logic [N_W-1:0]   res_n;
  logic [SUM_W-1:0] res_sum;
  logic             res_err;

  modport slave (
    input  req_valid, req_n, sum_in, res_ready,
    output req_ready, sum_n, sum_rst, res_valid, res_n, res_sum, res_err
  );

  modport master (
    output req_valid, req_n, sum_in, res_ready,
    input  req_ready, sum_n, sum_rst, res_valid, res_n, res_sum, res_err
  );
endinterface

// File: rtl/summation_feeder.sv
// Sequencer for the summation stage: takes N, restarts the stage, waits its
// data-dependent latency, captures the sum and returns {N, sum}. N outside
// [PIPE_MIN, PIPE_MAX] is answered directly without touching the stage.
// Optional feature macro: SUMMATION_CHECK_EN (adds a checker of the captured
// sum against N*(N+1)/2 with chk_mismatch / chk_cnt outputs).
module summation_feeder #(
  parameter int N_W      = 4,
  parameter int SUM_W    = 7,
  parameter int PIPE_MIN = 2,
  parameter int PIPE_MAX = 8
) (
  input  logic clock,
  input  logic reset,
`ifdef SUMMATION_CHECK_EN
  output logic       chk_mismatch,
  output logic [7:0] chk_cnt,
`endif
  summation_feeder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, KICK, WAIT, HOLD} state_t;

  localparam logic [N_W-1:0] N_MIN = N_W'(PIPE_MIN);
  localparam logic [N_W-1:0] N_MAX = N_W'(PIPE_MAX);

  state_t           state_q, state_d;
  logic [N_W-1:0]   wcnt_q, wcnt_d;
  logic [N_W-1:0]   sum_n_q, sum_n_d;
  logic [N_W-1:0]   res_n_q, res_n_d;
  logic [SUM_W-1:0] res_sum_q, res_sum_d;
  logic             res_err_q, res_err_d;
  logic             in_range;
  logic             capture;

  assign in_range = (bus.req_n >= N_MIN) && (bus.req_n <= N_MAX);
  // The stage is sampled on the cycle the wait counter has run out.
  assign capture  = (state_q == WAIT) && (wcnt_q == '0);

`ifdef SUMMATION_CHECK_EN
  logic             chk_mismatch_q, chk_mismatch_d;
  logic [7:0]       chk_cnt_q, chk_cnt_d;
  logic [SUM_W-1:0] n_ext, n_p1, tri_prod, sum_exp;
  logic             miss;

  // Reference triangular number; in-range N keeps the product inside SUM_W.
  always_comb begin
    n_ext    = SUM_W'(sum_n_q);
    n_p1     = n_ext + SUM_W'(1);
    tri_prod = n_ext * n_p1;
    sum_exp  = tri_prod >> 1;
    miss     = (bus.sum_in != sum_exp);
  end

  // Mismatch flag travels with the result; counter saturates at 255.
  always_comb begin
    chk_mismatch_d = chk_mismatch_q;
    chk_cnt_d      = chk_cnt_q;
    if (state_q == IDLE && bus.req_valid && !in_range) chk_mismatch_d = 1'b0;
    if (capture) begin
      chk_mismatch_d = miss;
      if (miss && chk_cnt_q != 8'hFF) chk_cnt_d = chk_cnt_q + 8'd1;
    end
  end

  // Checker state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      chk_mismatch_q <= 1'b0;
      chk_cnt_q      <= '0;
    end else begin
      chk_mismatch_q <= chk_mismatch_d;
      chk_cnt_q      <= chk_cnt_d;
    end
  end

  assign chk_mismatch = chk_mismatch_q;
  assign chk_cnt      = chk_cnt_q;
`endif

  // State register plus datapath flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      sum_n_q   <= '0;
      res_n_q   <= '0;
      res_sum_q <= '0;
      res_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      sum_n_q   <= sum_n_d;
      res_n_q   <= res_n_d;
      res_sum_q <= res_sum_d;
      res_err_q <= res_err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = in_range ? KICK : HOLD;
      KICK:    state_d = WAIT;
      WAIT:    if (wcnt_q == '0) state_d = HOLD;
      HOLD:    if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates: latch N, load/run the wait counter, capture results.
  always_comb begin
    wcnt_d    = wcnt_q;
    sum_n_d   = sum_n_q;
    res_n_d   = res_n_q;
    res_sum_d = res_sum_q;
    res_err_d = res_err_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        if (in_range) begin
          sum_n_d = bus.req_n;
        end else begin
          // 0/1 are their own sums; too-large N is flagged with a zero sum.
          res_n_d   = bus.req_n;
          res_err_d = (bus.req_n > N_MAX);
          res_sum_d = (bus.req_n < N_MIN) ? SUM_W'(bus.req_n) : '0;
        end
      end
      // N+1 puts the capture in the stage's done window, before it reloads.
      KICK: wcnt_d = sum_n_q + N_W'(1);
      WAIT: if (wcnt_q == '0) begin
        res_sum_d = bus.sum_in;
        res_n_d   = sum_n_q;
        res_err_d = 1'b0;
      end else begin
        wcnt_d = wcnt_q - N_W'(1);
      end
      default: ;
    endcase
  end

  // Handshake and stage-control outputs decoded from state.
  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.res_valid = (state_q == HOLD);
    bus.sum_rst   = reset | (state_q == KICK);
    bus.sum_n     = sum_n_q;
    bus.res_n     = res_n_q;
    bus.res_sum   = res_sum_q;
    bus.res_err   = res_err_q;
  end

endmodule

// File: tb/tb_summation_feeder.sv
// Directed bench for summation_feeder with a behavioural summation stage.
module tb_summation_feeder;
  logic clock;
  logic reset;
  logic fault;
  int   checks = 0;
  int   errors = 0;

  summation_feeder_if bus ();

`ifdef SUMMATION_CHECK_EN
  logic       chk_mismatch;
  logic [7:0] chk_cnt;
`endif

  summation_feeder dut (
    .clock        (clock),
    .reset        (reset),
`ifdef SUMMATION_CHECK_EN
    .chk_mismatch (chk_mismatch),
    .chk_cnt      (chk_cnt),
`endif
    .bus          (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Stage model: reset -> load N -> add N, N-1 .. 1 -> done window -> reload.
  logic       st_run;
  logic [3:0] st_cnt;
  logic [6:0] st_acc;
  always @(posedge clock) begin
    if (bus.sum_rst) begin
      st_run <= 1'b0;
      st_acc <= '0;
      st_cnt <= '0;
    end else if (!st_run) begin
      st_run <= 1'b1;
      st_acc <= '0;
      st_cnt <= bus.sum_n;
    end else if (st_cnt != 0) begin
      st_acc <= st_acc + 7'(st_cnt);
      st_cnt <= st_cnt - 4'd1;
    end else begin
      st_run <= 1'b0;
    end
  end
  assign bus.sum_in = fault ? 7'd0 : st_acc;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [3:0] n);
    bus.req_valid = 1'b1;
    bus.req_n     = n;
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Cycles from acceptance to res_valid (bounded), sum_rst pulses, sum_n stability.
  task automatic wait_res(input logic [3:0] exp_n, output int lat, output int pulses,
                          output bit stable);
    lat = 1; pulses = 0; stable = 1'b1;
    while (bus.res_valid !== 1'b1 && lat < 40) begin
      if (bus.sum_rst === 1'b1) pulses++;
      if (bus.sum_n !== exp_n) stable = 1'b0;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; fault = 1'b0;
    bus.req_valid = 1'b0; bus.req_n = '0; bus.res_ready = 1'b1;
    tick();
    checks++; if (bus.sum_rst !== 1'b1) begin errors++; $display("FAIL rst_sum_rst: got %b exp 1", bus.sum_rst); end
    tick();
    reset = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b exp 1", bus.req_ready); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid: got %b exp 0", bus.res_valid); end
    checks++; if (bus.sum_n !== 4'd0) begin errors++; $display("FAIL rst_sum_n: got %0d exp 0", bus.sum_n); end
    checks++; if (bus.res_sum !== 7'd0 || bus.res_n !== 4'd0 || bus.res_err !== 1'b0) begin
      errors++; $display("FAIL rst_res: got sum %0d n %0d err %b exp 0 0 0", bus.res_sum, bus.res_n, bus.res_err); end
`ifdef SUMMATION_CHECK_EN
    checks++; if (chk_cnt !== 8'd0 || chk_mismatch !== 1'b0) begin
      errors++; $display("FAIL rst_chk: got cnt %0d mis %b exp 0 0", chk_cnt, chk_mismatch); end
`endif
  endtask

  task automatic test_in_range();
    int lat, pulses; bit stable;
    send(4'd5);
    wait_res(4'd5, lat, pulses, stable);
    checks++; if (lat != 9) begin errors++; $display("FAIL n5_latency: got %0d exp 9", lat); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL n5_kick: got %0d exp 1", pulses); end
    checks++; if (!stable) begin errors++; $display("FAIL n5_sum_n_stable: got 0 exp 1"); end
    checks++; if (bus.res_sum !== 7'd15) begin errors++; $display("FAIL n5_sum: got %0d exp 15", bus.res_sum); end
    checks++; if (bus.res_n !== 4'd5 || bus.res_err !== 1'b0) begin
      errors++; $display("FAIL n5_n_err: got %0d %b exp 5 0", bus.res_n, bus.res_err); end
`ifdef SUMMATION_CHECK_EN
    checks++; if (chk_mismatch !== 1'b0) begin errors++; $display("FAIL n5_chk: got %b exp 0", chk_mismatch); end
`endif
    tick();
    checks++; if (bus.res_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL n5_release: got valid %b ready %b exp 0 1", bus.res_valid, bus.req_ready); end
  endtask

  task automatic test_bypass();
    int lat, pulses; bit stable;
    send(4'd1);
    wait_res(4'd5, lat, pulses, stable);
    checks++; if (lat != 1 || pulses != 0) begin errors++; $display("FAIL n1_latency: got %0d/%0d exp 1/0", lat, pulses); end
    checks++; if (bus.res_sum !== 7'd1 || bus.res_n !== 4'd1 || bus.res_err !== 1'b0) begin
      errors++; $display("FAIL n1_res: got %0d %0d %b exp 1 1 0", bus.res_sum, bus.res_n, bus.res_err); end
    checks++; if (bus.sum_n !== 4'd5) begin errors++; $display("FAIL n1_sum_n_kept: got %0d exp 5", bus.sum_n); end
    tick();
    send(4'd0);
    wait_res(4'd5, lat, pulses, stable);
    checks++; if (lat != 1 || bus.sum_rst !== 1'b0) begin errors++; $display("FAIL n0_latency: got %0d rst %b exp 1 0", lat, bus.sum_rst); end
    checks++; if (bus.res_sum !== 7'd0 || bus.res_n !== 4'd0 || bus.res_err !== 1'b0) begin
      errors++; $display("FAIL n0_res: got %0d %0d %b exp 0 0 0", bus.res_sum, bus.res_n, bus.res_err); end
    tick();
  endtask

  task automatic test_err();
    int lat, pulses; bit stable;
    send(4'd12);
    wait_res(4'd5, lat, pulses, stable);
    checks++; if (lat != 1 || bus.sum_rst !== 1'b0) begin errors++; $display("FAIL n12_latency: got %0d rst %b exp 1 0", lat, bus.sum_rst); end
    checks++; if (bus.res_err !== 1'b1 || bus.res_sum !== 7'd0 || bus.res_n !== 4'd12) begin
      errors++; $display("FAIL n12_res: got err %b sum %0d n %0d exp 1 0 12", bus.res_err, bus.res_sum, bus.res_n); end
`ifdef SUMMATION_CHECK_EN
    checks++; if (chk_mismatch !== 1'b0) begin errors++; $display("FAIL n12_chk: got %b exp 0", chk_mismatch); end
`endif
    tick();
  endtask

  task automatic test_back_to_back();
    int lat, pulses; bit stable;
    bus.res_ready = 1'b0;
    send(4'd8);
    wait_res(4'd8, lat, pulses, stable);
    checks++; if (lat != 12 || bus.res_sum !== 7'd36) begin
      errors++; $display("FAIL n8_res: got lat %0d sum %0d exp 12 36", lat, bus.res_sum); end
    bus.req_valid = 1'b1; bus.req_n = 4'd2;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (bus.res_valid !== 1'b1 || bus.res_sum !== 7'd36 || bus.req_ready !== 1'b0 || bus.res_n !== 4'd8) begin
        errors++; $display("FAIL n8_hold[%0d]: got v %b sum %0d rdy %b n %0d exp 1 36 0 8", i, bus.res_valid, bus.res_sum, bus.req_ready, bus.res_n); end
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    checks++; if (bus.req_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
      errors++; $display("FAIL n8_exit: got rdy %b v %b exp 1 0", bus.req_ready, bus.res_valid); end
    tick();
    bus.req_valid = 1'b0;
    wait_res(4'd2, lat, pulses, stable);
    checks++; if (lat != 6 || bus.res_sum !== 7'd3 || bus.res_n !== 4'd2) begin
      errors++; $display("FAIL n2_res: got lat %0d sum %0d n %0d exp 6 3 2", lat, bus.res_sum, bus.res_n); end
    bus.res_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    int seen;
    send(4'd7);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.sum_n !== 4'd0) begin
      errors++; $display("FAIL mid_reset: got rdy %b v %b sum_n %0d exp 1 0 0", bus.req_ready, bus.res_valid, bus.sum_n); end
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.res_valid === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL mid_no_result: got %0d exp 0", seen); end
`ifdef SUMMATION_CHECK_EN
    begin
      int lat, pulses; bit stable;
      fault = 1'b1;
      send(4'd4);
      wait_res(4'd4, lat, pulses, stable);
      checks++; if (lat != 8 || bus.res_sum !== 7'd0) begin
        errors++; $display("FAIL chk_res: got lat %0d sum %0d exp 8 0", lat, bus.res_sum); end
      checks++; if (chk_mismatch !== 1'b1 || chk_cnt !== 8'd1) begin
        errors++; $display("FAIL chk_flag: got mis %b cnt %0d exp 1 1", chk_mismatch, chk_cnt); end
      fault = 1'b0;
      tick();
    end
`endif
  endtask

  initial begin
    test_reset();
    test_in_range();
    test_bypass();
    test_err();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
